// File: rtl/gpr_wb_arbiter_pkg.sv
// rtl/gpr_wb_arbiter_pkg.sv - shared widths and write-port encodings for the GPR write-back path
package gpr_wb_arbiter_pkg;

    localparam int WORD_WIDTH     = 32;
    localparam int GPR_ADDR_WIDTH = 5;

    // Register file write enable is active low.
    localparam logic WRITE = 1'b0;
    localparam logic READ  = 1'b1;

    localparam logic [GPR_ADDR_WIDTH-1:0] X0_INDEX = '0;

endpackage

// File: rtl/gpr_wb_arbiter_wb_fifo.sv
// rtl/gpr_wb_arbiter_wb_fifo.sv - in-order LSU result FIFO exposing its entries for pending compare
module wb_fifo #(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             push,
    input  logic [ADDR_WIDTH-1:0]            push_rd,
    input  logic [WORD_WIDTH-1:0]            push_data,
    input  logic                             pop,
    output logic [ADDR_WIDTH-1:0]            head_rd,
    output logic [WORD_WIDTH-1:0]            head_data,
    output logic                             full,
    output logic                             empty,
    output logic [$clog2(DEPTH):0]           count,
    output logic [DEPTH-1:0][ADDR_WIDTH-1:0] entry_rd,
    output logic [DEPTH-1:0]                 entry_valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic [DEPTH-1:0]      valid_q;
    logic [ADDR_WIDTH-1:0] rd_mem   [DEPTH];
    logic [WORD_WIDTH-1:0] data_mem [DEPTH];
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign count       = count_q;
    assign head_rd     = rd_mem[rd_ptr];
    assign head_data   = data_mem[rd_ptr];
    assign entry_valid = valid_q;

    // Flatten the destination array so the top can compare every slot.
    always_comb begin
        entry_rd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_rd[i] = rd_mem[i];
        end
    end

    // Pointers, occupancy and per-slot valid bits; pointers wrap on power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr          <= rd_ptr + PW'(1);
                valid_q[rd_ptr] <= 1'b0;
            end
            if (do_push) begin
                wr_ptr          <= wr_ptr + PW'(1);
                valid_q[wr_ptr] <= 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Payload storage needs no reset; slot validity is tracked separately.
    always_ff @(posedge clk) begin
        if (do_push) begin
            rd_mem[wr_ptr]   <= push_rd;
            data_mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// rtl/gpr_wb_arbiter.sv - merges ALU and LSU results onto the single GPR write port
module gpr_wb_arbiter
    import gpr_wb_arbiter_pkg::*;
#(
    parameter int WORD_WIDTH = gpr_wb_arbiter_pkg::WORD_WIDTH,
    parameter int ADDR_WIDTH = GPR_ADDR_WIDTH,
    parameter int LSU_DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alu_valid,
    input  logic [ADDR_WIDTH-1:0]      alu_rd,
    input  logic [WORD_WIDTH-1:0]      alu_data,
    input  logic                       lsu_valid,
    output logic                       lsu_ready,
    input  logic [ADDR_WIDTH-1:0]      lsu_rd,
    input  logic [WORD_WIDTH-1:0]      lsu_data,
    output logic                       we_,
    output logic [ADDR_WIDTH-1:0]      wr_addr,
    output logic [WORD_WIDTH-1:0]      wr_data,
    input  logic [ADDR_WIDTH-1:0]      chk_addr,
    output logic                       chk_pending,
    output logic [$clog2(LSU_DEPTH):0] lsu_cnt
);

    logic                                 fifo_full;
    logic                                 fifo_empty;
    logic [ADDR_WIDTH-1:0]                head_rd;
    logic [WORD_WIDTH-1:0]                head_data;
    logic [LSU_DEPTH-1:0][ADDR_WIDTH-1:0] entry_rd;
    logic [LSU_DEPTH-1:0]                 entry_valid;

    logic                  alu_live;
    logic                  lsu_live;
    logic                  do_write;
    logic                  do_pop;
    logic                  do_push;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [WORD_WIDTH-1:0] sel_data;

    // Ready comes only from registered occupancy, so no pop-through when full.
    assign lsu_ready = !fifo_full;
    assign alu_live  = alu_valid && (alu_rd != ADDR_WIDTH'(X0_INDEX));
    // x0 LSU transfers still handshake but are dropped here.
    assign lsu_live  = lsu_valid && lsu_ready && (lsu_rd != ADDR_WIDTH'(X0_INDEX));

    // Priority select: ALU, then FIFO head, then LSU bypass; leftover LSU results are queued.
    always_comb begin
        do_write = 1'b0;
        do_pop   = 1'b0;
        do_push  = 1'b0;
        sel_addr = wr_addr;
        sel_data = wr_data;
        if (alu_live) begin
            do_write = 1'b1;
            sel_addr = alu_rd;
            sel_data = alu_data;
            do_push  = lsu_live;
        end else if (!fifo_empty) begin
            do_write = 1'b1;
            do_pop   = 1'b1;
            sel_addr = head_rd;
            sel_data = head_data;
            do_push  = lsu_live;
        end else if (lsu_live) begin
            do_write = 1'b1;
            sel_addr = lsu_rd;
            sel_data = lsu_data;
        end
    end

    // Decode interlock: any valid queued entry whose destination matches; x0 never pends.
    always_comb begin
        chk_pending = 1'b0;
        for (int i = 0; i < LSU_DEPTH; i++) begin
            if (entry_valid[i] && (entry_rd[i] == chk_addr)) begin
                chk_pending = 1'b1;
            end
        end
        if (chk_addr == ADDR_WIDTH'(X0_INDEX)) begin
            chk_pending = 1'b0;
        end
    end

    // Registered write port; address and data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_     <= READ;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (do_write) begin
            we_     <= WRITE;
            wr_addr <= sel_addr;
            wr_data <= sel_data;
        end else begin
            we_     <= READ;
        end
    end

    wb_fifo #(
        .WORD_WIDTH (WORD_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (LSU_DEPTH)
    ) u_wb_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (do_push),
        .push_rd     (lsu_rd),
        .push_data   (lsu_data),
        .pop         (do_pop),
        .head_rd     (head_rd),
        .head_data   (head_data),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .count       (lsu_cnt),
        .entry_rd    (entry_rd),
        .entry_valid (entry_valid)
    );

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb/tb_gpr_wb_arbiter.sv - directed self-checking bench for gpr_wb_arbiter
module tb_gpr_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        we_;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  chk_addr;
    logic        chk_pending;
    logic [1:0]  lsu_cnt;

    int checks = 0;
    int errors = 0;

    gpr_wb_arbiter #(
        .WORD_WIDTH (32),
        .ADDR_WIDTH (5),
        .LSU_DEPTH  (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .we_         (we_),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .chk_addr    (chk_addr),
        .chk_pending (chk_pending),
        .lsu_cnt     (lsu_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        alu_valid = v;
        alu_rd    = rd;
        alu_data  = d;
    endtask

    task automatic lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        lsu_valid = v;
        lsu_rd    = rd;
        lsu_data  = d;
    endtask

    task automatic expect_write(input string tag, input logic [4:0] a, input logic [31:0] d);
        check({tag, "_we"}, {31'd0, we_}, 32'd0);
        check({tag, "_addr"}, {27'd0, wr_addr}, {27'd0, a});
        check({tag, "_data"}, wr_data, d);
    endtask

    initial begin
        rst_n    = 1'b0;
        chk_addr = 5'd0;
        alu(1'b1, 5'd3, 32'hAAAA_0003);
        lsu(1'b1, 5'd4, 32'hBBBB_0004);

        // 1. Reset holds outputs idle despite active inputs
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_we", {31'd0, we_}, 32'd1);
            check("rst_addr", {27'd0, wr_addr}, 32'd0);
            check("rst_data", wr_data, 32'd0);
            check("rst_ready", {31'd0, lsu_ready}, 32'd1);
            check("rst_cnt", {30'd0, lsu_cnt}, 32'd0);
        end
        alu(1'b0, 5'd0, 32'd0);
        lsu(1'b0, 5'd0, 32'd0);
        rst_n = 1'b1;
        step();
        check("idle_we", {31'd0, we_}, 32'd1);

        // 2. ALU only
        alu(1'b1, 5'd5, 32'hDEAD_BEEF);
        step();
        expect_write("alu", 5'd5, 32'hDEAD_BEEF);
        alu(1'b0, 5'd0, 32'd0);
        step();
        check("alu_after_we", {31'd0, we_}, 32'd1);
        check("alu_hold_addr", {27'd0, wr_addr}, 32'd5);

        // 3. LSU bypass
        lsu(1'b1, 5'd7, 32'h0000_1234);
        check("byp_ready", {31'd0, lsu_ready}, 32'd1);
        step();
        expect_write("byp", 5'd7, 32'h0000_1234);
        check("byp_cnt", {30'd0, lsu_cnt}, 32'd0);
        lsu(1'b0, 5'd0, 32'd0);
        step();
        check("byp_after_we", {31'd0, we_}, 32'd1);

        // 4. Contention and full
        chk_addr = 5'd9;
        alu(1'b1, 5'd1, 32'h11);
        lsu(1'b1, 5'd9, 32'h99);
        step();
        expect_write("c1", 5'd1, 32'h11);
        check("c1_cnt", {30'd0, lsu_cnt}, 32'd1);
        check("c1_pend9", {31'd0, chk_pending}, 32'd1);
        alu(1'b1, 5'd2, 32'h22);
        lsu(1'b1, 5'd10, 32'hA0);
        step();
        expect_write("c2", 5'd2, 32'h22);
        check("c2_cnt", {30'd0, lsu_cnt}, 32'd2);
        check("c2_ready", {31'd0, lsu_ready}, 32'd0);
        alu(1'b1, 5'd3, 32'h33);
        lsu(1'b1, 5'd11, 32'hB0);
        step();
        expect_write("c3", 5'd3, 32'h33);
        check("c3_cnt", {30'd0, lsu_cnt}, 32'd2);
        check("c3_pend9", {31'd0, chk_pending}, 32'd1);
        alu(1'b1, 5'd4, 32'h44);
        step();
        expect_write("c4", 5'd4, 32'h44);
        check("c4_ready", {31'd0, lsu_ready}, 32'd0);
        alu(1'b0, 5'd0, 32'd0);
        step();
        expect_write("c9", 5'd9, 32'h99);
        check("c9_cnt", {30'd0, lsu_cnt}, 32'd1);
        check("c9_pend9", {31'd0, chk_pending}, 32'd0);
        check("c9_ready", {31'd0, lsu_ready}, 32'd1);
        step();
        expect_write("c10", 5'd10, 32'hA0);
        check("c10_cnt", {30'd0, lsu_cnt}, 32'd1);
        lsu(1'b0, 5'd0, 32'd0);
        chk_addr = 5'd11;
        #1;
        check("c10_pend11", {31'd0, chk_pending}, 32'd1);
        step();
        expect_write("c11", 5'd11, 32'hB0);
        check("c11_cnt", {30'd0, lsu_cnt}, 32'd0);
        step();
        check("c_end_we", {31'd0, we_}, 32'd1);

        // 5. x0 filtering
        alu(1'b1, 5'd0, 32'hFFFF_FFFF);
        lsu(1'b1, 5'd0, 32'hEEEE_EEEE);
        chk_addr = 5'd0;
        check("x0_ready", {31'd0, lsu_ready}, 32'd1);
        step();
        check("x0_we", {31'd0, we_}, 32'd1);
        check("x0_cnt", {30'd0, lsu_cnt}, 32'd0);
        check("x0_pend", {31'd0, chk_pending}, 32'd0);
        alu(1'b0, 5'd0, 32'd0);
        lsu(1'b0, 5'd0, 32'd0);
        step();
        check("x0_we2", {31'd0, we_}, 32'd1);

        // 6. Reset mid-queue
        alu(1'b1, 5'd12, 32'hC0);
        lsu(1'b1, 5'd13, 32'hD0);
        step();
        alu(1'b1, 5'd14, 32'hE0);
        lsu(1'b1, 5'd15, 32'hF0);
        step();
        check("mq_cnt", {30'd0, lsu_cnt}, 32'd2);
        expect_write("mq_alu", 5'd14, 32'hE0);
        alu(1'b0, 5'd0, 32'd0);
        lsu(1'b0, 5'd0, 32'd0);
        chk_addr = 5'd13;
        #2;
        rst_n = 1'b0;
        #1;
        check("mq_async_cnt", {30'd0, lsu_cnt}, 32'd0);
        check("mq_async_we", {31'd0, we_}, 32'd1);
        check("mq_async_pend", {31'd0, chk_pending}, 32'd0);
        check("mq_async_ready", {31'd0, lsu_ready}, 32'd1);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mq_post_we", {31'd0, we_}, 32'd1);
            check("mq_post_cnt", {30'd0, lsu_cnt}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
